// File: rtl/cpu_pkg.sv
// Shared definitions for the 23-bit-instruction CPU: opcodes, controller
// states, ALU operation codes and instruction field positions.
package cpu_pkg;

    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_ADD   = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_AND   = 5'd3;
    localparam logic [4:0] OP_OR    = 5'd4;
    localparam logic [4:0] OP_LOAD  = 5'd5;
    localparam logic [4:0] OP_STORE = 5'd6;
    localparam logic [4:0] OP_LOADI = 5'd7;
    localparam logic [4:0] OP_BEQ   = 5'd8;
    localparam logic [4:0] OP_JMP   = 5'd9;
    localparam logic [4:0] OP_HALT  = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_AND    = 3'd2;
    localparam logic [2:0] ALU_OR     = 3'd3;
    localparam logic [2:0] ALU_PASS_B = 3'd4;

    localparam int INSTR_W     = 23;
    localparam int OPCODE_MSB  = 22;
    localparam int OPCODE_LSB  = 18;
    localparam int REGD_MSB    = 17;
    localparam int REGD_LSB    = 16;
    localparam int REGS_MSB    = 15;
    localparam int REGS_LSB    = 14;
    localparam int REGT_MSB    = 13;
    localparam int REGT_LSB    = 12;
    localparam int OFFSET_MSB  = 11;
    localparam int OFFSET_LSB  = 0;

    function automatic logic is_legal(input logic [4:0] op);
        return (op <= OP_JMP) || (op == OP_HALT);
    endfunction

    // Returns {alu_op, alu_src_imm}; anything without an ALU role gets ADD/regT.
    function automatic logic [3:0] alu_decode(input logic [4:0] op);
        case (op)
            OP_ADD:            return {ALU_ADD, 1'b0};
            OP_SUB:            return {ALU_SUB, 1'b0};
            OP_AND:            return {ALU_AND, 1'b0};
            OP_OR:             return {ALU_OR, 1'b0};
            OP_LOAD, OP_STORE: return {ALU_ADD, 1'b1};
            OP_LOADI:          return {ALU_PASS_B, 1'b1};
            OP_BEQ:            return {ALU_SUB, 1'b0};
            default:           return {ALU_ADD, 1'b0};
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: fetch, decode, execute, memory and writeback
// sequencing plus a wrapping retired-instruction counter.
module multicycle_controller
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16,
    localparam int OP_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OP_W-1:0]  opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic [2:0]       alu_op,
    output logic             alu_src_imm,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs are decoded from state_q/op_q, so reset clears them at once.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        retire      = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 1'b0;
        halted      = 1'b0;
        illegal     = 1'b0;
        busy        = (state_q != S_IDLE) && (state_q != S_HALT);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (!is_legal(opcode) || opcode == OP_NOP) begin
                    illegal = !is_legal(opcode);
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (opcode == OP_HALT) begin
                    retire  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                {alu_op, alu_src_imm} = alu_decode(op_q);
                case (op_q)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOADI: state_d = S_WB;
                    OP_LOAD, OP_STORE:                       state_d = S_MEM;
                    OP_BEQ: begin
                        pc_load = zero;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_load = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                {alu_op, alu_src_imm} = alu_decode(op_q);
                if (op_q == OP_STORE) begin
                    mem_wr = 1'b1;
                end else begin
                    mem_rd = 1'b1;
                end
                if (mem_ready) begin
                    if (op_q == OP_STORE) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                {alu_op, alu_src_imm} = alu_decode(op_q);
                reg_we  = 1'b1;
                wb_sel  = (op_q == OP_LOAD);
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cnt_d       = retire ? cnt_q + CNT_W'(1) : cnt_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed vector table, randomized
// instruction stream against a per-instruction trace model, and corner sequences.
module tb_multicycle_controller;
    import cpu_pkg::*;

    localparam int B_RD = 13, B_WR = 12, B_IRL = 11, B_PCI = 10, B_PCL = 9;
    localparam int B_IMM = 5, B_WE = 4, B_WBS = 3, B_BUSY = 2, B_HALT = 1, B_ILL = 0;
    localparam logic [13:0] ALL = 14'h3fff;

    typedef struct packed {
        logic        mr;
        logic        zr;
        logic [13:0] exp;
        logic [13:0] care;
        state_t      st;
    } cyc_t;

    typedef struct {
        logic [4:0] op;
        logic       zr;
        int         fw;
        int         mw;
        int         lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_rd, mem_wr, ir_load, pc_inc, pc_load;
    logic [2:0]  alu_op;
    logic        alu_src_imm, reg_we, wb_sel, busy, halted, illegal;
    logic [15:0] instr_count;
    logic        w_rd, w_wr, w_irl, w_pci, w_pcl, w_imm, w_we, w_wbs, w_busy, w_halt, w_ill;
    logic [2:0]  w_alu;
    logic [3:0]  instr_count_w;
    logic [13:0] outs;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = '0;
    cyc_t        trace_q[$];
    vec_t        vecs[14];

    always #5 clk = ~clk;

    multicycle_controller #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_load(ir_load),
        .pc_inc(pc_inc), .pc_load(pc_load), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
        .reg_we(reg_we), .wb_sel(wb_sel), .busy(busy), .halted(halted),
        .illegal(illegal), .instr_count(instr_count)
    );

    // Narrow counter copy driven identically: exercises the wrap to zero.
    multicycle_controller #(.CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_rd(w_rd), .mem_wr(w_wr), .ir_load(w_irl),
        .pc_inc(w_pci), .pc_load(w_pcl), .alu_op(w_alu), .alu_src_imm(w_imm),
        .reg_we(w_we), .wb_sel(w_wbs), .busy(w_busy), .halted(w_halt),
        .illegal(w_ill), .instr_count(instr_count_w)
    );

    assign outs = {mem_rd, mem_wr, ir_load, pc_inc, pc_load, alu_op,
                   alu_src_imm, reg_we, wb_sel, busy, halted, illegal};

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [13:0] bt(int n);
        return 14'(1) << n;
    endfunction

    function automatic logic [13:0] alu(logic [2:0] a, logic imm);
        return {5'b0, a, imm, 5'b0};
    endfunction

    function automatic cyc_t cyc(state_t st, logic mr, logic [13:0] e, logic [13:0] care);
        cyc_t c;
        c.st   = st;
        c.mr   = mr;
        c.zr   = 1'($urandom_range(0, 1));
        c.exp  = e | bt(B_BUSY);
        c.care = care;
        return c;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected cycle-by-cycle trace of one instruction, from fetch to retire.
    function automatic void build(logic [4:0] op, logic z, int fw, int mw);
        cyc_t        c;
        logic        legal;
        logic [13:0] rq;
        trace_q.delete();
        legal = (op <= 5'd9) || (op == 5'd31);
        for (int i = 0; i < fw; i++) trace_q.push_back(cyc(S_FETCH, 1'b0, bt(B_RD), ALL));
        trace_q.push_back(cyc(S_FETCH, 1'b1, bt(B_RD) | bt(B_IRL) | bt(B_PCI), ALL));
        trace_q.push_back(cyc(S_DECODE, rnd(), legal ? 14'd0 : bt(B_ILL), ALL));
        if (op >= 5'd1 && op <= 5'd4) begin
            trace_q.push_back(cyc(S_EXEC, rnd(), alu(3'(op - 5'd1), 1'b0), ALL));
            trace_q.push_back(cyc(S_WB, rnd(), alu(3'(op - 5'd1), 1'b0) | bt(B_WE), ALL & ~bt(B_IMM)));
        end else if (op == 5'd7) begin
            trace_q.push_back(cyc(S_EXEC, rnd(), alu(3'd4, 1'b1), ALL));
            trace_q.push_back(cyc(S_WB, rnd(), alu(3'd4, 1'b0) | bt(B_WE), ALL & ~bt(B_IMM)));
        end else if (op == 5'd5 || op == 5'd6) begin
            rq = (op == 5'd5) ? bt(B_RD) : bt(B_WR);
            trace_q.push_back(cyc(S_EXEC, rnd(), alu(3'd0, 1'b1), ALL));
            for (int i = 0; i < mw; i++) trace_q.push_back(cyc(S_MEM, 1'b0, alu(3'd0, 1'b1) | rq, ALL));
            trace_q.push_back(cyc(S_MEM, 1'b1, alu(3'd0, 1'b1) | rq, ALL));
            if (op == 5'd5)
                trace_q.push_back(cyc(S_WB, rnd(), alu(3'd0, 1'b0) | bt(B_WE) | bt(B_WBS), ALL & ~bt(B_IMM)));
        end else if (op == 5'd8) begin
            c = cyc(S_EXEC, rnd(), alu(3'd1, 1'b0) | (z ? bt(B_PCL) : 14'd0), ALL);
            c.zr = z;
            trace_q.push_back(c);
        end else if (op == 5'd9) begin
            c = cyc(S_EXEC, rnd(), bt(B_PCL), ALL & ~alu(3'd7, 1'b1));
            c.zr = z;
            trace_q.push_back(c);
        end
    endfunction

    task automatic apply(int n);
        for (int i = 0; i < n; i++) begin
            if (i >= trace_q.size()) begin
                errors++;
                $display("FAIL trace_len: cycle %0d beyond model trace of %0d", i, trace_q.size());
                return;
            end
            mem_ready = trace_q[i].mr;
            zero      = trace_q[i].zr;
            #1;
            check("outs", 32'(outs & trace_q[i].care), 32'(trace_q[i].exp & trace_q[i].care));
            check("state", 32'(dut.state_q), 32'(trace_q[i].st));
            @(negedge clk);
        end
    endtask

    task automatic run_instr(logic [4:0] op, logic z, int fw, int mw, int lat);
        opcode = op;
        build(op, z, fw, mw);
        apply(lat < 0 ? trace_q.size() : lat);
        exp_cnt++;
        mem_ready = 1'b0;
        #1;
        check("end_state", 32'(dut.state_q), 32'(op == 5'd31 ? S_HALT : S_FETCH));
        check("count", 32'(instr_count), 32'(exp_cnt));
        check("count_wrap", 32'(instr_count_w), 32'(exp_cnt[3:0]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] op;
        vecs[0]  = '{5'd1,  1'b0, 0, 0, 4};
        vecs[1]  = '{5'd5,  1'b0, 0, 3, 8};
        vecs[2]  = '{5'd8,  1'b1, 0, 0, 3};
        vecs[3]  = '{5'd8,  1'b0, 0, 0, 3};
        vecs[4]  = '{5'd9,  1'b0, 0, 0, 3};
        vecs[5]  = '{5'd9,  1'b1, 0, 0, 3};
        vecs[6]  = '{5'd0,  1'b0, 0, 0, 2};
        vecs[7]  = '{5'd2,  1'b0, 0, 0, 4};
        vecs[8]  = '{5'd3,  1'b0, 1, 0, 5};
        vecs[9]  = '{5'd4,  1'b0, 0, 0, 4};
        vecs[10] = '{5'd7,  1'b0, 0, 0, 4};
        vecs[11] = '{5'd6,  1'b0, 2, 1, 7};
        vecs[12] = '{5'd17, 1'b0, 0, 0, 2};
        vecs[13] = '{5'd5,  1'b0, 0, 0, 5};

        rst_n = 1'b0; start = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", 32'(outs), 32'd0);
        check("reset_count", 32'(instr_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_state", 32'(dut.state_q), 32'(S_IDLE));
        check("idle_outs", 32'(outs), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("start_fetch", 32'(dut.state_q), 32'(S_FETCH));

        foreach (vecs[i]) run_instr(vecs[i].op, vecs[i].zr, vecs[i].fw, vecs[i].mw, vecs[i].lat);

        for (int n = 0; n < 200; n++) begin
            op = 5'($urandom_range(0, 11));
            if (op > 5'd9) op = 5'($urandom_range(10, 30));
            run_instr(op, rnd(), $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end

        run_instr(5'd31, 1'b0, 1, 0, 3);
        for (int i = 0; i < 4; i++) begin
            start = 1'b1;
            mem_ready = rnd();
            #1;
            check("halt_outs", 32'(outs), 32'(bt(B_HALT)));
            check("halt_state", 32'(dut.state_q), 32'(S_HALT));
            check("halt_count", 32'(instr_count), 32'(exp_cnt));
            @(negedge clk);
        end
        start = 1'b0;

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        opcode = 5'd6;
        build(5'd6, 1'b0, 0, 5);
        apply(3);
        mem_ready = 1'b0;
        #1;
        check("store_mem_wr", 32'(mem_wr), 32'd1);
        check("store_state", 32'(dut.state_q), 32'(S_MEM));
        rst_n = 1'b0;
        #1;
        check("abort_outs", 32'(outs), 32'd0);
        check("abort_state", 32'(dut.state_q), 32'(S_IDLE));
        check("abort_count", 32'(instr_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        #1;
        check("restart_idle", 32'(outs), 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("restart_fetch", 32'(dut.state_q), 32'(S_FETCH));
        run_instr(5'd1, 1'b0, 0, 0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control FSM that sequences the 23-bit-instruction datapath: instruction fetch, decode, ALU execute, data-memory access and register writeback.
- Consumes the 5-bit opcode from the instruction-field decoder, plus the ALU zero flag and the memory ready flag.
- Drives every datapath enable and select, and counts retired instructions.

Parameters:
- CNT_W, 16: width of the retired-instruction counter.
- OP_W, 5: opcode width; fixed by the instruction format and not to be overridden.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin execution; sampled only in IDLE.
- opcode  in  OP_W  opcode field of the instruction register; valid from DECODE onward.
- zero  in  1  ALU zero flag; sampled in EXEC.
- mem_ready  in  1  memory has completed the current read or write.
- mem_rd  out  1  memory read request; used for both instruction fetch and LOAD.
- mem_wr  out  1  memory write request, issued for STORE.
- ir_load  out  1  load the instruction register.
- pc_inc  out  1  increment PC by 1.
- pc_load  out  1  load PC from offset; takes priority over pc_inc in the datapath.
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 PASS_B.
- alu_src_imm  out  1  ALU B operand = sign-extended offset rather than regT.
- reg_we  out  1  write regD.
- wb_sel  out  1  writeback source: 0 ALU result, 1 memory data.
- busy  out  1  state is neither IDLE nor HALT.
- halted  out  1  state is HALT.
- illegal  out  1  one-cycle pulse in DECODE when the opcode is undefined.
- instr_count  out  CNT_W  number of retired instructions.

Behaviour:
- Opcodes:
  - 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 LOAD, 6 STORE, 7 LOADI, 8 BEQ, 9 JMP, 31 HALT.
  - All other opcodes are illegal and execute as NOP.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Reset value is IDLE.
- Reset values: every output is 0 and instr_count is 0. Assertion of rst_n mid-operation aborts immediately and clears all outputs asynchronously, including any pending memory request.
- IDLE:
  - start=1 moves to FETCH.
  - start is ignored in every other state.
- FETCH:
  - mem_rd=1 is held until mem_ready.
  - In the mem_ready cycle: ir_load=1 and pc_inc=1, then go to DECODE.
  - Wait states are unbounded.
- DECODE:
  - Register opcode into op_q; all later states use op_q only.
  - NOP or illegal: retire, go to FETCH; illegal=1 for this cycle when illegal.
  - HALT: retire, go to HALT.
  - All other opcodes: go to EXEC.
- EXEC:
  - alu_op and alu_src_imm are decoded from op_q.
    - ADD, SUB, AND, OR: alu_op 0, 1, 2, 3.
    - LOAD and STORE: ADD with immediate.
    - LOADI: PASS_B with immediate.
    - BEQ: SUB.
  - Transitions:
    - ALU ops and LOADI go to WB.
    - LOAD and STORE go to MEM.
    - BEQ: pc_load=zero, retire, go to FETCH.
    - JMP: pc_load=1, retire, go to FETCH.
- MEM:
  - alu_op and alu_src_imm are held from EXEC.
  - mem_rd (LOAD) or mem_wr (STORE) is held until mem_ready.
  - On mem_ready: LOAD goes to WB; STORE retires and goes to FETCH.
- WB:
  - reg_we=1 for exactly one cycle; wb_sel=1 for LOAD, 0 otherwise; alu_op is held.
  - Retire, go to FETCH.
- HALT: absorbing state; all control outputs 0, halted=1. Only reset exits.
- mem_ready outside a request cycle is ignored.
- mem_rd and mem_wr are never asserted together.
- Retire: instr_count += 1, wrapping from 2^CNT_W-1 to 0. NOP, illegal and HALT each count as one retired instruction.
- Latency with zero-wait memory (mem_ready tied 1):
  - NOP: 2 cycles.
  - BEQ, JMP: 3 cycles.
  - ALU, LOADI, STORE: 4 cycles.
  - LOAD: 5 cycles.
- Control outputs are Moore (decoded from state and op_q). Exceptions: ir_load, pc_inc and the MEM exit are qualified by mem_ready, and pc_load by zero.

Decomposition:
- cpu_pkg holds:
  - The opcode localparams.
  - The state enum.
  - The alu_op encodings.
  - Instruction field bit positions: opcode [22:18], regD [17:16], regS [15:14], regT [13:12], offset [11:0].
  - A pure function is_legal(opcode).
- No sub-module; the counter and the FSM live in one module.

Test Plan:
- rst_n low then high, start=1 for 1 cycle, mem_ready=1, opcode=1 (ADD) -> states FETCH, DECODE, EXEC, WB; alu_op=0 in EXEC; reg_we=1, wb_sel=0 in WB; instr_count=1; back in FETCH.
- LOAD (opcode 5) with mem_ready low for 3 cycles in MEM -> mem_rd held 4 cycles; alu_op=0, alu_src_imm=1; WB has reg_we=1, wb_sel=1; total latency 8 cycles.
- BEQ (opcode 8) with zero=1, then BEQ with zero=0 -> pc_load=1 in EXEC for the first only; JMP (opcode 9) -> pc_load=1 regardless of zero.
- Opcode 17 -> illegal=1 for exactly the DECODE cycle, no reg_we/mem_* asserted, instr_count increments, next state FETCH; opcode 31 -> halted=1, busy=0, start ignored; stays halted until rst_n.
- STORE (opcode 6) with rst_n asserted while mem_wr=1 in MEM -> mem_wr drops asynchronously, state IDLE, instr_count=0; start restarts at FETCH.
- Preload 16'hFFFF via 65535 NOPs (or force), retire one more -> instr_count=0.
